fb_write_arbiter: RTL and testbench

Write-side controller for the byte-enabled simple dual-port frame/board RAM. It shares the RAM's single write port between two requesters, the game-logic cell writer and the score/text overlay writer, using valid/ready handshakes and round-robin arbitration. It also contains a clear engine that sweeps every word to a fill value. The read port is untouched and stays with the VGA/draw logic.

---
 rtl/fb_arb_pkg.sv | 21 ++
 rtl/fb_rr_arbiter.sv | 29 ++
 rtl/fb_write_arbiter.sv | 131 +++++++++++++
 tb/tb_fb_write_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// Shared types and default geometry for the frame/board RAM write arbiter.
package fb_arb_pkg;

  localparam int FB_ADDRESS_WIDTH = 12;
  localparam int FB_DEPTH         = 1200;
  localparam int FB_BYTE_WIDTH    = 8;
  localparam int FB_NUM_BYTES     = 4;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  // One write request at the default geometry.
  typedef struct packed {
    logic [FB_ADDRESS_WIDTH-1:0]           addr;
    logic [FB_NUM_BYTES-1:0]               be;
    logic [FB_BYTE_WIDTH*FB_NUM_BYTES-1:0] wdata;
  } fb_req_t;

endpackage

// File: rtl/fb_rr_arbiter.sv
// Two-way round-robin arbiter. The grant is combinational and one-hot;
// the last-grant pointer moves on every grant (grant implies transfer,
// since grant is only raised for a valid requester).
module fb_rr_arbiter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  logic last;  // index of the requester granted most recently

  // On a tie, favour whichever requester did not win last time.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) grant = last ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end

  // Pointer resets to "requester 1 last" so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset_n)    last <= 1'b1;
    else if (|grant) last <= grant[1];
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Write-port controller for the byte-enabled frame/board RAM: round-robin
// sharing between game logic (req0) and overlay (req1), plus a clear engine
// that fills every word. The clear engine is built only when FB_ARB_CLEAR_EN
// is defined; otherwise clear_start/clear_value are ignored.
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FB_ADDRESS_WIDTH,
  parameter int DEPTH         = FB_DEPTH,
  parameter int BYTE_WIDTH    = FB_BYTE_WIDTH,
  parameter int NUM_BYTES     = FB_NUM_BYTES
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            req0_valid,
  output logic                            req0_ready,
  input  logic [ADDRESS_WIDTH-1:0]        req0_addr,
  input  logic [NUM_BYTES-1:0]            req0_be,
  input  logic [BYTE_WIDTH*NUM_BYTES-1:0] req0_wdata,
  input  logic                            req1_valid,
  output logic                            req1_ready,
  input  logic [ADDRESS_WIDTH-1:0]        req1_addr,
  input  logic [NUM_BYTES-1:0]            req1_be,
  input  logic [BYTE_WIDTH*NUM_BYTES-1:0] req1_wdata,
  input  logic                            clear_start,
  input  logic [BYTE_WIDTH*NUM_BYTES-1:0] clear_value,
  output logic                            clear_busy,
  output logic                            addr_err,
  output logic                            ram_we,
  output logic [ADDRESS_WIDTH-1:0]        ram_waddr,
  output logic [NUM_BYTES-1:0]            ram_be,
  output logic [BYTE_WIDTH*NUM_BYTES-1:0] ram_wdata
);

  localparam int W = BYTE_WIDTH * NUM_BYTES;
  // One extra bit so DEPTH == 2**ADDRESS_WIDTH still compares correctly.
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_W   = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  logic                     arb_en;
  logic [1:0]               grant;
  logic                     xfer;
  logic                     g_legal;
  logic [ADDRESS_WIDTH-1:0] g_addr;
  logic [NUM_BYTES-1:0]     g_be;
  logic [W-1:0]             g_wdata;

`ifdef FB_ARB_CLEAR_EN
  localparam logic [0:0] S_ARB   = ARB;
  localparam logic [0:0] S_CLEAR = CLEAR;

  logic [0:0]               state;
  logic [ADDRESS_WIDTH-1:0] clr_cnt;  // address currently on ram_waddr during a sweep

  // No grants while sweeping, and a start pulse beats any request.
  assign arb_en     = reset_n && (state == S_ARB) && !clear_start;
  assign clear_busy = (state == S_CLEAR);
`else
  logic unused_clr;

  assign arb_en     = reset_n;
  assign clear_busy = 1'b0;
  assign unused_clr = ^{clear_start, clear_value};
`endif

  fb_rr_arbiter u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   ({req1_valid, req0_valid}),
    .enable  (arb_en),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign xfer       = |grant;

  // Select the granted request and check its address against the RAM size.
  always_comb begin
    g_addr  = grant[1] ? req1_addr  : req0_addr;
    g_be    = grant[1] ? req1_be    : req0_be;
    g_wdata = grant[1] ? req1_wdata : req0_wdata;
    g_legal = ({1'b0, g_addr} < DEPTH_W);
  end

  // Output registers and clear sweep; an illegal transfer is swallowed and
  // flagged instead of reaching the RAM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_be    <= '0;
      ram_wdata <= '0;
      addr_err  <= 1'b0;
`ifdef FB_ARB_CLEAR_EN
      state     <= S_ARB;
      clr_cnt   <= '0;
    end else if (state == S_CLEAR) begin
      // ram_wdata still holds the fill word latched at the start pulse.
      addr_err <= 1'b0;
      ram_be   <= '1;
      if (clr_cnt == LAST_ADDR) begin
        state   <= S_ARB;
        ram_we  <= 1'b0;
        clr_cnt <= '0;
      end else begin
        ram_we    <= 1'b1;
        clr_cnt   <= clr_cnt + 1'b1;
        ram_waddr <= clr_cnt + 1'b1;
      end
    end else if (clear_start) begin
      state     <= S_CLEAR;
      clr_cnt   <= '0;
      ram_we    <= 1'b1;
      ram_waddr <= '0;
      ram_be    <= '1;
      ram_wdata <= clear_value;
      addr_err  <= 1'b0;
`endif
    end else begin
      ram_we   <= xfer && g_legal;
      addr_err <= xfer && !g_legal;
      if (xfer && g_legal) begin
        ram_waddr <= g_addr;
        ram_be    <= g_be;
        ram_wdata <= g_wdata;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural model of the arbitration, clear and RAM contents.
`timescale 1ns/1ps
module tb_fb_write_arbiter;
  import fb_arb_pkg::*;

  localparam int AW = 12;
  localparam int DEPTH = 1200;
  localparam int NB = 4;
  localparam int W = 32;
`ifdef FB_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr, ram_waddr;
  logic [NB-1:0] req0_be, req1_be, ram_be;
  logic [W-1:0] req0_wdata, req1_wdata, clear_value, ram_wdata;
  logic clear_start, clear_busy, addr_err, ram_we;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fb_write_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_be(req0_be), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_be(req1_be), .req1_wdata(req1_wdata),
    .clear_start(clear_start), .clear_value(clear_value), .clear_busy(clear_busy),
    .addr_err(addr_err), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_be(ram_be), .ram_wdata(ram_wdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                         input logic [NB-1:0] be);
    logic [W-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Bench-side RAM fed by the DUT's write port.
  logic [W-1:0] tram [DEPTH];
  always @(posedge clk)
    if (ram_we === 1'b1 && int'(ram_waddr) < DEPTH)
      tram[ram_waddr] = merge(tram[ram_waddr], ram_wdata, ram_be);

  // Behavioural model: expected registered outputs for the current cycle.
  bit           e_we, e_err, e_full;
  logic [AW-1:0] e_waddr;
  logic [NB-1:0] e_be;
  logic [W-1:0]  e_wdata;
  int           m_left;   // clear words still to be shown on the port
  bit           m_last;   // requester granted most recently
  logic [W-1:0] mmem [DEPTH];

  initial begin
    int tx, a;
    for (int i = 0; i < DEPTH; i++) begin mmem[i] = '0; tram[i] = '0; end
    e_we = 0; e_err = 0; e_full = 1; e_waddr = '0; e_be = '0; e_wdata = '0;
    m_left = 0; m_last = 1;
    forever begin
      @(negedge clk);
      tx = -1;
      if (reset_n && !(CLR_EN && (m_left > 0 || clear_start))) begin
        if (req0_valid && req1_valid) tx = m_last ? 0 : 1;
        else if (req0_valid) tx = 0;
        else if (req1_valid) tx = 1;
      end
      chk("cyc req0_ready", 64'(req0_ready), 64'(tx == 0));
      chk("cyc req1_ready", 64'(req1_ready), 64'(tx == 1));
      chk("cyc ram_we", 64'(ram_we), 64'(e_we));
      chk("cyc addr_err", 64'(addr_err), 64'(e_err));
      chk("cyc clear_busy", 64'(clear_busy), 64'(m_left > 0));
      if (e_we || e_full) begin
        chk("cyc ram_waddr", 64'(ram_waddr), 64'(e_waddr));
        chk("cyc ram_be", 64'(ram_be), 64'(e_be));
        chk("cyc ram_wdata", 64'(ram_wdata), 64'(e_wdata));
      end
      // The write on the port now is committed by the coming edge.
      if (e_we && int'(e_waddr) < DEPTH) mmem[e_waddr] = merge(mmem[e_waddr], e_wdata, e_be);
      e_full = 0;
      if (!reset_n) begin
        e_we = 0; e_err = 0; e_full = 1; e_waddr = '0; e_be = '0; e_wdata = '0;
        m_left = 0; m_last = 1;
      end else if (CLR_EN && m_left > 0) begin
        m_left--;
        e_err = 0;
        if (m_left == 0) e_we = 0;
        else begin e_we = 1; e_waddr = AW'(DEPTH - m_left); end
      end else if (CLR_EN && clear_start) begin
        m_left = DEPTH; e_we = 1; e_err = 0; e_waddr = '0; e_be = '1; e_wdata = clear_value;
      end else if (tx >= 0) begin
        a = tx == 1 ? int'(req1_addr) : int'(req0_addr);
        e_we = a < DEPTH;
        e_err = !(a < DEPTH);
        if (a < DEPTH) begin
          e_waddr = AW'(a);
          e_be = tx == 1 ? req1_be : req0_be;
          e_wdata = tx == 1 ? req1_wdata : req0_wdata;
        end
        m_last = (tx == 1);
      end else begin
        e_we = 0; e_err = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bcnt, bad;
    reset_n = 0; clear_start = 0; clear_value = '0;
    req0_valid = 1; req0_addr = 10; req0_be = 4'hF; req0_wdata = 32'h01010101;
    req1_valid = 1; req1_addr = 20; req1_be = 4'hF; req1_wdata = 32'h02020202;
    step(); step(); step();
    #1;
    chk("reset req0_ready", 64'(req0_ready), 0);
    chk("reset req1_ready", 64'(req1_ready), 0);
    chk("reset ram_we", 64'(ram_we), 0);
    chk("reset ram_waddr", 64'(ram_waddr), 0);
    chk("reset ram_wdata", 64'(ram_wdata), 0);
    chk("reset clear_busy", 64'(clear_busy), 0);

    // Both requesters valid back to back: strict alternation starting with req0.
    reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      req0_addr = AW'(100 + i); req1_addr = AW'(200 + i);
      req0_wdata = $urandom; req1_wdata = $urandom;
      #1;
      chk("rr grant", 64'({req1_ready, req0_ready}), (i % 2) ? 64'h2 : 64'h1);
      if (i > 0) begin
        chk("rr ram_we", 64'(ram_we), 1);
        chk("rr ram_waddr", 64'(ram_waddr), ((i - 1) % 2) ? 64'(200 + i - 1) : 64'(100 + i - 1));
      end
      step();
    end

    // Single-byte write: only lane 1 changes.
    req1_valid = 0;
    req0_addr = 5; req0_be = 4'b0010; req0_wdata = 32'hAABBCCDD;
    step();
    req0_valid = 0;
    #1;
    chk("be ram_we", 64'(ram_we), 1);
    chk("be ram_waddr", 64'(ram_waddr), 5);
    chk("be ram_be", 64'(ram_be), 64'h2);
    chk("be ram_wdata", 64'(ram_wdata), 64'hAABBCCDD);
    step(); step();
    chk("be readback", 64'(tram[5]), 64'h0000CC00);

    // Out-of-range address is accepted but dropped; the last legal word is written.
    req1_valid = 1; req1_addr = 1200; req1_be = 4'hF; req1_wdata = 32'h12345678;
    step();
    req1_addr = 1199;
    #1;
    chk("ill ram_we", 64'(ram_we), 0);
    chk("ill addr_err", 64'(addr_err), 1);
    step();
    req1_valid = 0;
    #1;
    chk("edge ram_we", 64'(ram_we), 1);
    chk("edge ram_waddr", 64'(ram_waddr), 1199);
    chk("edge addr_err", 64'(addr_err), 0);
    step();

    // Randomized traffic with occasional resets and clear pulses.
    for (int i = 0; i < 500; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      clear_start = ($urandom_range(0, 199) == 0);
      clear_value = $urandom;
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      req0_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 4095)) : AW'($urandom_range(0, DEPTH - 1));
      req1_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 4095)) : AW'($urandom_range(0, DEPTH - 1));
      req0_be = NB'($urandom); req1_be = NB'($urandom);
      req0_wdata = $urandom; req1_wdata = $urandom;
      step();
    end
    reset_n = 1; clear_start = 0; req0_valid = 0; req1_valid = 0;
    step();
    for (int c = 0; c < DEPTH + 10 && clear_busy; c++) step();
    step();

`ifdef FB_ARB_CLEAR_EN
    // Clear with a competing request; restart attempt mid-sweep is ignored.
    req0_valid = 1; req0_addr = 7; req0_be = 4'hF; req0_wdata = 32'h77777777;
    clear_start = 1; clear_value = 32'h0;
    #1;
    chk("clr start blocks req0", 64'(req0_ready), 0);
    step();
    clear_start = 0;
    chk("clr first busy", 64'(clear_busy), 1);
    chk("clr first addr", 64'(ram_waddr), 0);
    bcnt = 0;
    for (int c = 0; c < DEPTH + 10 && clear_busy; c++) begin
      bcnt++;
      clear_start = (c == 500);
      step();
    end
    clear_start = 0;
    chk("clr busy cycles", 64'(bcnt), 64'(DEPTH));
    chk("clr ready after", 64'(req0_ready), 1);
    step();
    req0_valid = 0;
    step(); step();
    chk("clr word 1199", 64'(tram[1199]), 0);
    chk("clr word 7", 64'(tram[7]), 64'h77777777);

    // Reset in the middle of a sweep.
    clear_start = 1; clear_value = 32'hDEADBEEF;
    step();
    clear_start = 0;
    for (int c = 0; c < DEPTH && ram_waddr != 600; c++) step();
    chk("mid addr reached", 64'(ram_waddr), 600);
    reset_n = 0; req0_valid = 1; req0_addr = 3;
    step();
    chk("mid ram_we", 64'(ram_we), 0);
    chk("mid clear_busy", 64'(clear_busy), 0);
    reset_n = 1;
    #1;
    chk("mid ready after", 64'(req0_ready), 1);
    step();
    req0_valid = 0;
    step();
    chk("mid word 599", 64'(tram[599]), 64'hDEADBEEF);
    chk("mid word 601", 64'(tram[601]), 0);
`else
    // Without the clear engine a start pulse changes nothing.
    req0_valid = 1; req0_addr = 9; req0_be = 4'hF; req0_wdata = 32'h99999999;
    clear_start = 1; clear_value = 32'h0;
    #1;
    chk("noclr req0_ready", 64'(req0_ready), 1);
    step();
    clear_start = 0; req0_valid = 0;
    chk("noclr clear_busy", 64'(clear_busy), 0);
    chk("noclr ram_we", 64'(ram_we), 1);
    chk("noclr ram_waddr", 64'(ram_waddr), 9);
    step();
`endif

    step(); step();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (tram[i] !== mmem[i]) bad++;
    chk("ram image words differing", 64'(bad), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
